// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - tagged load/store responder for the proc2mem/mem2proc bus
//
// Purpose: synthesizable stand-in for the behavioural memory model. One
// BUS_LOAD/BUS_STORE can be accepted per cycle; each accepted request gets a
// 4-bit tag combinationally in the same cycle. Load data comes back tagged
// exactly LATENCY cycles after the accept.
//
// Ports:
//   clock              system clock, all state updates on posedge
//   reset              asynchronous, active-low
//   proc2mem_command   00 none, 01 load, 10 store, 11 none
//   proc2mem_addr      byte address, line index = addr[31:3]
//   proc2mem_data      store data, right-justified
//   proc2mem_size      00 byte, 01 half, 10 word, 11 double (stores only)
//   mem2proc_response  tag granted this cycle, 0 = not accepted
//   mem2proc_data      returned load data, 0 when no return
//   mem2proc_tag       tag of the load returning this cycle, 0 = none

module mem_responder #(
  parameter int MEM_LINES = 8192,
  parameter int LATENCY   = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  proc2mem_command,
  input  logic [31:0] proc2mem_addr,
  input  logic [63:0] proc2mem_data,
  input  logic [1:0]  proc2mem_size,
  output logic [3:0]  mem2proc_response,
  output logic [63:0] mem2proc_data,
  output logic [3:0]  mem2proc_tag
);

  localparam int          AW        = $clog2(MEM_LINES);
  localparam logic [31:0] LINES     = 32'(MEM_LINES);
  localparam int          DEPTH     = 15;
  localparam logic [1:0]  BUS_LOAD  = 2'b01;
  localparam logic [1:0]  BUS_STORE = 2'b10;
  localparam logic [1:0]  SZ_BYTE   = 2'b00;
  localparam logic [1:0]  SZ_HALF   = 2'b01;
  localparam logic [1:0]  SZ_WORD   = 2'b10;

  logic [63:0] unified_memory [MEM_LINES];

  logic          is_load, is_store, aligned, in_range, accept, acc_load, acc_store;
  logic [7:0]    size_mask, wmask;
  logic [63:0]   wdata_sh, rd_line;
  logic [AW-1:0] line_idx;
  logic [3:0]    next_tag;
  logic [15:0]   busy;

  logic [3:0]    fifo_tag  [DEPTH];
  logic [63:0]   fifo_data [DEPTH];
  logic [3:0]    wr_ptr, rd_ptr;
  logic          fifo_push, fifo_pop, pop;
  logic [3:0]    head_tag;
  logic [63:0]   head_data;

  assign line_idx = proc2mem_addr[3 +: AW];
  assign rd_line  = unified_memory[line_idx];

  always_comb begin
    is_load  = (proc2mem_command == BUS_LOAD);
    is_store = (proc2mem_command == BUS_STORE);
    case (proc2mem_size)
      SZ_BYTE: begin aligned = 1'b1;                        size_mask = 8'h01; end
      SZ_HALF: begin aligned = (proc2mem_addr[0] == 1'b0);   size_mask = 8'h03; end
      SZ_WORD: begin aligned = (proc2mem_addr[1:0] == 2'b0); size_mask = 8'h0F; end
      default: begin aligned = (proc2mem_addr[2:0] == 3'b0); size_mask = 8'hFF; end
    endcase
    in_range  = ({3'b000, proc2mem_addr[31:3]} < LINES);
    // Loads are line-granular, so alignment only gates stores.
    accept    = reset && (is_load || (is_store && aligned)) && in_range && !busy[next_tag];
    acc_load  = accept && is_load;
    acc_store = accept && is_store;
    mem2proc_response = accept ? next_tag : 4'd0;
    wmask    = size_mask << proc2mem_addr[2:0];
    wdata_sh = proc2mem_data << {proc2mem_addr[2:0], 3'b000};
  end

  // Memory contents survive reset; only bytes covered by the store are written.
  always_ff @(posedge clock) begin
    if (acc_store) begin
      for (int b = 0; b < 8; b++) begin
        if (wmask[b]) unified_memory[line_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  // Return timing: the output register must load at the end of cycle
  // accept+LATENCY-1. A one-hot-per-accept delay line marks that cycle while
  // the data itself waits in the in-order FIFO. LATENCY==1 bypasses the FIFO.
  generate
    if (LATENCY == 1) begin : g_bypass
      assign pop       = acc_load;
      assign head_tag  = next_tag;
      assign head_data = rd_line;
      assign fifo_push = 1'b0;
      assign fifo_pop  = 1'b0;
    end else begin : g_fifo
      logic [LATENCY-2:0] ret_pipe;
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          ret_pipe <= '0;
        end else begin
          ret_pipe[0] <= acc_load;
          for (int i = 1; i < LATENCY - 1; i++) ret_pipe[i] <= ret_pipe[i-1];
        end
      end
      assign pop       = ret_pipe[LATENCY-2];
      assign head_tag  = fifo_tag[rd_ptr];
      assign head_data = fifo_data[rd_ptr];
      assign fifo_push = acc_load;
      assign fifo_pop  = pop;
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (fifo_push) begin
      fifo_tag[wr_ptr]  <= next_tag;
      fifo_data[wr_ptr] <= rd_line;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem2proc_tag  <= 4'd0;
      mem2proc_data <= 64'd0;
      next_tag      <= 4'd1;
      busy          <= 16'd0;
      wr_ptr        <= 4'd0;
      rd_ptr        <= 4'd0;
    end else begin
      mem2proc_tag  <= pop ? head_tag  : 4'd0;
      mem2proc_data <= pop ? head_data : 64'd0;
      // The tag stays busy through its return cycle and frees at its end.
      if (mem2proc_tag != 4'd0) busy[mem2proc_tag] <= 1'b0;
      if (acc_load) busy[next_tag] <= 1'b1;
      if (accept) next_tag <= (next_tag == 4'd15) ? 4'd1 : next_tag + 4'd1;
      if (fifo_push) wr_ptr <= (wr_ptr == 4'(DEPTH-1)) ? 4'd0 : wr_ptr + 4'd1;
      if (fifo_pop)  rd_ptr <= (rd_ptr == 4'(DEPTH-1)) ? 4'd0 : rd_ptr + 4'd1;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder

module tb_mem_responder;

  localparam int LAT   = 10;
  localparam int LAT20 = 20;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  cmd, size, cmd20;
  logic [31:0] addr, addr20;
  logic [63:0] wdata;
  logic [3:0]  resp, rtag, resp20, rtag20;
  logic [63:0] rdata, rdata20;

  always #5 clock = ~clock;

  mem_responder #(.MEM_LINES(8192), .LATENCY(LAT)) dut (
    .clock(clock), .reset(reset),
    .proc2mem_command(cmd), .proc2mem_addr(addr), .proc2mem_data(wdata), .proc2mem_size(size),
    .mem2proc_response(resp), .mem2proc_data(rdata), .mem2proc_tag(rtag)
  );

  mem_responder #(.MEM_LINES(8192), .LATENCY(LAT20)) dut20 (
    .clock(clock), .reset(reset),
    .proc2mem_command(cmd20), .proc2mem_addr(addr20), .proc2mem_data(wdata), .proc2mem_size(size),
    .mem2proc_response(resp20), .mem2proc_data(rdata20), .mem2proc_tag(rtag20)
  );

  typedef struct {
    int          due;
    logic [3:0]  tag;
    logic [63:0] data;
    bit          chk;
  } ret_t;

  ret_t        inflight[$];
  logic [63:0] mem_m [64];
  bit          mem_known [64];
  int          m_next;
  int          cyc;
  int          n_cmp, n_fail;

  logic [3:0]  exp_resp, exp_tag, obs_resp, obs_tag, obs_resp20, obs_tag20;
  logic [63:0] exp_data, obs_data;
  bit          exp_chk;

  function automatic bit tag_busy(int t);
    foreach (inflight[i]) if (int'(inflight[i].tag) == t) return 1'b1;
    return 1'b0;
  endfunction

  // One bus cycle on the main DUT: drive, predict, sample at negedge, advance model.
  task automatic step(input logic [1:0] c, input logic [31:0] a, input logic [63:0] d,
                      input logic [1:0] s);
    int line, off, nb;
    bit acc, algn;
    ret_t e;
    cmd = c; addr = a; wdata = d; size = s;
    line = int'(a[31:3]);
    off  = int'(a[2:0]);
    nb   = 1 << int'(s);
    algn = ((off % nb) == 0);
    acc  = (reset == 1'b1) && (c == 2'd1 || c == 2'd2) && (line < 8192) &&
           (c == 2'd1 || algn) && !tag_busy(m_next);
    exp_resp = acc ? 4'(m_next) : 4'd0;
    exp_tag = 4'd0; exp_data = 64'd0; exp_chk = 1'b1;
    foreach (inflight[i]) begin
      if (inflight[i].due == cyc) begin
        exp_tag = inflight[i].tag; exp_data = inflight[i].data; exp_chk = inflight[i].chk;
      end
    end
    @(negedge clock);
    obs_resp = resp; obs_tag = rtag; obs_data = rdata;
    obs_resp20 = resp20; obs_tag20 = rtag20;
    @(posedge clock);
    #1;
    while (inflight.size() > 0 && inflight[0].due <= cyc) void'(inflight.pop_front());
    if (acc) begin
      if (c == 2'd1) begin
        e.due = cyc + LAT; e.tag = 4'(m_next);
        e.data = (line < 64) ? mem_m[line] : 64'd0;
        e.chk  = (line < 64) ? mem_known[line] : 1'b0;
        inflight.push_back(e);
      end else if (line < 64) begin
        for (int b = 0; b < nb; b++) mem_m[line][8*(off+b) +: 8] = d[8*b +: 8];
        if (nb == 8) mem_known[line] = 1'b1;
      end
      m_next = (m_next == 15) ? 1 : m_next + 1;
    end
    cyc++;
  endtask

  task automatic test_reset;
    reset = 1'b0; cmd20 = 2'd1; addr20 = 32'h0;
    inflight.delete(); m_next = 1;
    step(2'd1, 32'h0, 64'd0, 2'd3);
    n_cmp++; if (obs_resp !== 4'd0) begin n_fail++; $display("FAIL reset_resp got %0d want 0", obs_resp); end
    n_cmp++; if (obs_tag !== 4'd0) begin n_fail++; $display("FAIL reset_tag got %0d want 0", obs_tag); end
    n_cmp++; if (obs_data !== 64'd0) begin n_fail++; $display("FAIL reset_data got %h want 0", obs_data); end
    n_cmp++; if (obs_resp20 !== 4'd0) begin n_fail++; $display("FAIL reset_resp20 got %0d want 0", obs_resp20); end
    cmd20 = 2'd0;
    reset = 1'b1;
    step(2'd1, 32'h0, 64'd0, 2'd3);
    n_cmp++; if (obs_resp !== 4'd1) begin n_fail++; $display("FAIL first_load_resp got %0d want 1", obs_resp); end
  endtask

  task automatic test_init_memory;
    for (int l = 0; l < 64; l++) begin
      step(2'd2, 32'(l * 8), {$urandom, $urandom}, 2'd3);
      n_cmp++; if (obs_resp !== exp_resp) begin n_fail++; $display("FAIL init_resp cyc=%0d got %0d want %0d", cyc, obs_resp, exp_resp); end
      n_cmp++; if (obs_tag !== exp_tag) begin n_fail++; $display("FAIL init_tag cyc=%0d got %0d want %0d", cyc, obs_tag, exp_tag); end
    end
  endtask

  task automatic test_store_load;
    logic [3:0] ld_tag;
    int hits, hit_i;
    logic [63:0] hit_data;
    step(2'd2, 32'h100, 64'h1122334455667788, 2'd3);
    n_cmp++; if (obs_resp !== exp_resp || obs_resp === 4'd0) begin n_fail++; $display("FAIL sl_store_resp got %0d want %0d", obs_resp, exp_resp); end
    step(2'd1, 32'h100, 64'd0, 2'd0);
    ld_tag = exp_resp;
    n_cmp++; if (obs_resp !== exp_resp || obs_resp === 4'd0) begin n_fail++; $display("FAIL sl_load_resp got %0d want %0d", obs_resp, exp_resp); end
    hits = 0; hit_i = -1; hit_data = 64'd0;
    for (int i = 1; i <= LAT + 3; i++) begin
      step(2'd0, 32'h0, 64'd0, 2'd0);
      if (obs_tag === ld_tag) begin hits++; hit_i = i; hit_data = obs_data; end
      n_cmp++; if (obs_tag !== exp_tag) begin n_fail++; $display("FAIL sl_tag i=%0d got %0d want %0d", i, obs_tag, exp_tag); end
      if (exp_chk) begin
        n_cmp++; if (obs_data !== exp_data) begin n_fail++; $display("FAIL sl_data i=%0d got %h want %h", i, obs_data, exp_data); end
      end
    end
    n_cmp++; if (hits != 1) begin n_fail++; $display("FAIL sl_hits got %0d want 1", hits); end
    n_cmp++; if (hit_i != LAT) begin n_fail++; $display("FAIL sl_latency got %0d want %0d", hit_i, LAT); end
    n_cmp++; if (hit_data !== 64'h1122334455667788) begin n_fail++; $display("FAIL sl_value got %h want 1122334455667788", hit_data); end
  endtask

  task automatic test_byte_store;
    logic [3:0] ld_tag;
    logic [63:0] got;
    step(2'd2, 32'h103, 64'hAB, 2'd0);
    n_cmp++; if (obs_resp !== exp_resp || obs_resp === 4'd0) begin n_fail++; $display("FAIL byte_resp got %0d want %0d", obs_resp, exp_resp); end
    step(2'd2, 32'h102, 64'hDEADBEEF, 2'd2);
    n_cmp++; if (obs_resp !== 4'd0) begin n_fail++; $display("FAIL misaligned_resp got %0d want 0", obs_resp); end
    step(2'd1, 32'h100, 64'd0, 2'd0);
    ld_tag = exp_resp; got = 64'd0;
    for (int i = 1; i <= LAT + 1; i++) begin
      step(2'd0, 32'h0, 64'd0, 2'd0);
      if (obs_tag === ld_tag) got = obs_data;
      n_cmp++; if (obs_tag !== exp_tag) begin n_fail++; $display("FAIL byte_tag i=%0d got %0d want %0d", i, obs_tag, exp_tag); end
    end
    n_cmp++; if (got !== 64'h11223344AB667788) begin n_fail++; $display("FAIL byte_line got %h want 11223344ab667788", got); end
  endtask

  task automatic test_range_and_snapshot;
    logic [3:0] ld_tag;
    logic [63:0] pre, got;
    step(2'd1, 32'h10000, 64'd0, 2'd3);
    n_cmp++; if (obs_resp !== 4'd0) begin n_fail++; $display("FAIL range_resp got %0d want 0", obs_resp); end
    pre = mem_m[63];
    step(2'd1, 32'h1F8, 64'd0, 2'd3);
    ld_tag = exp_resp;
    n_cmp++; if (obs_resp !== exp_resp || obs_resp === 4'd0) begin n_fail++; $display("FAIL snap_load_resp got %0d want %0d", obs_resp, exp_resp); end
    step(2'd2, 32'h1F8, ~pre, 2'd3);
    got = 64'd0;
    for (int i = 2; i <= LAT + 1; i++) begin
      step(2'd0, 32'h0, 64'd0, 2'd0);
      if (obs_tag === ld_tag) got = obs_data;
    end
    n_cmp++; if (got !== pre) begin n_fail++; $display("FAIL snapshot got %h want %h", got, pre); end
  endtask

  task automatic test_random;
    int line_r, off;
    logic [1:0] c, s;
    for (int n = 0; n < 400; n++) begin
      line_r = $urandom_range(0, 63);
      if ($urandom_range(0, 15) == 0) line_r = 8192 + $urandom_range(0, 100);
      off = $urandom_range(0, 7);
      c = 2'($urandom_range(0, 3));
      s = 2'($urandom_range(0, 3));
      step(c, 32'(line_r * 8 + off), {$urandom, $urandom}, s);
      n_cmp++; if (obs_resp !== exp_resp) begin n_fail++; $display("FAIL rnd_resp n=%0d got %0d want %0d", n, obs_resp, exp_resp); end
      n_cmp++; if (obs_tag !== exp_tag) begin n_fail++; $display("FAIL rnd_tag n=%0d got %0d want %0d", n, obs_tag, exp_tag); end
      if (exp_chk) begin
        n_cmp++; if (obs_data !== exp_data) begin n_fail++; $display("FAIL rnd_data n=%0d got %h want %h", n, obs_data, exp_data); end
      end
    end
    for (int n = 0; n < LAT + 2; n++) step(2'd0, 32'h0, 64'd0, 2'd0);
  endtask

  task automatic test_full;
    logic [3:0] want;
    addr20 = 32'h0;
    for (int k = 0; k <= 21; k++) begin
      cmd20 = 2'd1;
      want = (k < 15) ? 4'(k + 1) : ((k < 21) ? 4'd0 : 4'd1);
      step(2'd0, 32'h0, 64'd0, 2'd0);
      n_cmp++; if (obs_resp20 !== want) begin n_fail++; $display("FAIL full_resp k=%0d got %0d want %0d", k, obs_resp20, want); end
      if (k == 19 || k == 20) begin
        n_cmp++; if (obs_tag20 !== ((k == 20) ? 4'd1 : 4'd0)) begin n_fail++; $display("FAIL full_ret k=%0d got %0d", k, obs_tag20); end
      end
    end
    cmd20 = 2'd0;
  endtask

  task automatic test_reset_inflight;
    for (int i = 0; i < 3; i++) begin
      step(2'd1, 32'(i * 8), 64'd0, 2'd3);
      n_cmp++; if (obs_resp !== exp_resp || obs_resp === 4'd0) begin n_fail++; $display("FAIL rif_load_resp i=%0d got %0d want %0d", i, obs_resp, exp_resp); end
    end
    reset = 1'b0;
    inflight.delete(); m_next = 1;
    step(2'd0, 32'h0, 64'd0, 2'd0);
    reset = 1'b1;
    for (int i = 0; i < LAT + 5; i++) begin
      step(2'd0, 32'h0, 64'd0, 2'd0);
      n_cmp++; if (obs_tag !== 4'd0) begin n_fail++; $display("FAIL rif_stale_tag i=%0d got %0d want 0", i, obs_tag); end
    end
    step(2'd1, 32'h8, 64'd0, 2'd3);
    n_cmp++; if (obs_resp !== 4'd1) begin n_fail++; $display("FAIL rif_next_resp got %0d want 1", obs_resp); end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; cyc = 0; m_next = 1;
    cmd = 2'd0; addr = 32'h0; wdata = 64'd0; size = 2'd0;
    cmd20 = 2'd0; addr20 = 32'h0;
    for (int l = 0; l < 64; l++) begin mem_m[l] = 64'd0; mem_known[l] = 1'b0; end
    test_reset;
    test_init_memory;
    test_store_load;
    test_byte_store;
    test_range_and_snapshot;
    test_random;
    test_full;
    test_reset_inflight;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
